gf180mcu_osu_sc_gp12t3v3__clkmon: RTL and testbench
===================================================

GF180MCU_OSU_SC_GP12T3V3__CLKMON -- requirements
Module: gf180mcu_osu_sc_gp12t3v3__clkmon

Interface
REQ-001 SHALL have parameter CW, default 8, meaning the width of the period counter, thresholds and PER.
REQ-002 SHALL have port CLK, input, 1, meaning the reference clock; the block has one clock only.
REQ-003 SHALL have port RST, input, 1, meaning reset; it is synchronous and active-high.
REQ-004 SHALL have port A, input, 1, meaning the monitored clock (a buffered clock-tree leaf), asynchronous to CLK.
REQ-005 SHALL have port EN, input, 1, meaning monitor enable.
REQ-006 SHALL have port LO, input, CW, meaning the minimum legal period in CLK cycles, inclusive.
REQ-007 SHALL have port HI, input, CW, meaning the maximum legal period in CLK cycles, inclusive.
REQ-008 SHALL have port PER, output, CW, meaning the last measured period.
REQ-009 SHALL have port VLD, output, 1, meaning a one-cycle pulse when PER updates.
REQ-010 SHALL have ports FAST, SLOW and STUCK, output, 1 each, meaning sticky fault flags.
REQ-011 SHALL have port OK, output, 1, meaning at least one period has been measured and no fault flag is set.

Function
REQ-012 SHALL sample A through a two-flop synchronizer and a third history flop.
- Rising edge detected (RE) = sync2 & ~hist.
- Latency from A rising (setup met) to RE = 3 CLK cycles.
REQ-013 SHALL implement the FSM states IDLE, ACQ, MEAS and FAULT.
REQ-014 IDLE SHALL hold cnt=0; EN=1 moves the FSM to ACQ on the next cycle.
REQ-015 ACQ SHALL wait for the first RE, then load cnt=1 and enter MEAS; no PER or VLD is produced on that edge.
REQ-016 MEAS SHALL increment cnt by 1 per cycle.
- On RE: PER<=cnt, VLD=1 for one cycle, cnt<=1.
REQ-017 SHALL compare against thresholds in the same cycle as the PER update.
- FAST<=1 if cnt<LO.
- SLOW<=1 if cnt>HI.
- Comparison is unsigned.
REQ-018 SHALL saturate cnt at 2^CW-1; reaching it without RE sets STUCK and enters FAULT.
REQ-019 FAULT SHALL freeze cnt and PER and suppress VLD; only RST or EN=0 exits FAULT (to IDLE).
REQ-020 EN=0 in any state SHALL return the FSM to IDLE next cycle.
- PER and the flags hold their values.
- An RE coincident with EN falling is ignored.
REQ-021 Flags SHALL be sticky until RST or an IDLE->ACQ transition, which clears them.
REQ-022 If LO>HI, any measured period SHALL set FAST or SLOW (or both); no special handling.
REQ-023 OK SHALL be 1 only when state is MEAS, at least one VLD has occurred since ACQ, and FAST=SLOW=STUCK=0.
REQ-024 RE and saturation in the same cycle SHALL be treated as RE: PER=2^CW-1, STUCK not set.

Reset
REQ-025 RST=1 SHALL, at the next CLK edge, force state=IDLE, cnt=0, PER=0, VLD=0, FAST=SLOW=STUCK=0, OK=0 and all synchronizer flops to 0.
REQ-026 RST mid-measurement SHALL discard the partial count; there is no output glitch beyond the reset values.

Structure
REQ-027 SHALL keep the FSM state enum and the default CW constant in a shared package, gf180mcu_osu_sc_clkmon_pkg.
REQ-028 SHALL place the synchronizer in one sub-module, gf180mcu_osu_sc_gp12t3v3__sync2; all other logic is inline.
REQ-029 SHALL contain no latches and no logic clocked by A.

Verification
REQ-030 Reset release, EN=1, A toggled every 5 CLK (period 10), LO=8, HI=12 -> first VLD carries PER=10 about 3 cycles after the 2nd A rise; OK=1, no flags.
REQ-031 A period 4, LO=8 -> FAST=1 on the first VLD; FAST stays 1 after A returns to period 10; OK=0.
REQ-032 A period 20, HI=12 -> SLOW=1 with PER=20.
REQ-033 A held 0 after one edge, CW=8 -> STUCK=1 when cnt reaches 255; state FAULT; VLD stays low; EN 1->0->1 clears STUCK and re-enters ACQ.
REQ-034 RST asserted for 1 cycle mid-period -> all outputs at reset values on the next cycle; the next measurement needs two fresh A edges.
REQ-035 EN=0 coincident with RE -> no VLD, and PER keeps its previous value.

Source files
------------

// File: rtl/gf180mcu_osu_sc_clkmon_pkg.sv
// Shared types and constants for the clock-period monitor.
// Holds the FSM state encoding and the default counter width.
package gf180mcu_osu_sc_clkmon_pkg;

    localparam int CLKMON_CW_DEFAULT = 8;
    localparam int SYNC_STAGES       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_MEAS  = 2'd2,
        ST_FAULT = 2'd3
    } clkmon_state_e;

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__sync2.sv
// Two-flop synchronizer plus a history flop for the monitored clock.
// Produces a single-cycle rising-edge strobe in the reference domain.
module gf180mcu_osu_sc_gp12t3v3__sync2
    import gf180mcu_osu_sc_clkmon_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic a,
    output logic re
);

    logic [SYNC_STAGES-1:0] stage_reg;
    logic [SYNC_STAGES-1:0] stage_next;

    // Stage 0 captures the raw input; each later stage shifts the previous one.
    assign stage_next = {stage_reg[SYNC_STAGES-2:0], a};

    always_ff @(posedge clk) begin
        if (srst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign re = stage_reg[1] & ~stage_reg[2];

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkmon.sv
// Clock-period monitor: measures the period of A in CLK cycles and raises
// sticky FAST/SLOW/STUCK flags against the LO/HI window.
module gf180mcu_osu_sc_gp12t3v3__clkmon
    import gf180mcu_osu_sc_clkmon_pkg::*;
#(
    parameter int CW = CLKMON_CW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          A,
    input  logic          EN,
    input  logic [CW-1:0] LO,
    input  logic [CW-1:0] HI,
    output logic [CW-1:0] PER,
    output logic          VLD,
    output logic          FAST,
    output logic          SLOW,
    output logic          STUCK,
    output logic          OK
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          re;
    clkmon_state_e state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] per_reg, per_next;
    logic          vld_reg, vld_next;
    logic          fast_reg, fast_next;
    logic          slow_reg, slow_next;
    logic          stuck_reg, stuck_next;
    logic          seen_reg, seen_next;

    gf180mcu_osu_sc_gp12t3v3__sync2 u_sync (
        .clk  (CLK),
        .srst (RST),
        .a    (A),
        .re   (re)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            per_reg   <= '0;
            vld_reg   <= 1'b0;
            fast_reg  <= 1'b0;
            slow_reg  <= 1'b0;
            stuck_reg <= 1'b0;
            seen_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            per_reg   <= per_next;
            vld_reg   <= vld_next;
            fast_reg  <= fast_next;
            slow_reg  <= slow_next;
            stuck_reg <= stuck_next;
            seen_reg  <= seen_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        per_next   = per_reg;
        vld_next   = 1'b0;
        fast_next  = fast_reg;
        slow_next  = slow_reg;
        stuck_next = stuck_reg;
        seen_next  = seen_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (EN) begin
                    // Starting a fresh acquisition wipes the previous verdict.
                    state_next = ST_ACQ;
                    fast_next  = 1'b0;
                    slow_next  = 1'b0;
                    stuck_next = 1'b0;
                    seen_next  = 1'b0;
                end
            end
            ST_ACQ: begin
                if (!EN) begin
                    state_next = ST_IDLE;
                end else if (re) begin
                    cnt_next   = CNT_ONE;
                    state_next = ST_MEAS;
                end
            end
            ST_MEAS: begin
                if (!EN) begin
                    state_next = ST_IDLE;
                end else if (re) begin
                    // An edge on the saturated count still counts as a valid period.
                    per_next  = cnt_reg;
                    vld_next  = 1'b1;
                    cnt_next  = CNT_ONE;
                    seen_next = 1'b1;
                    if (cnt_reg < LO) fast_next = 1'b1;
                    if (cnt_reg > HI) slow_next = 1'b1;
                end else if (cnt_reg == CNT_MAX) begin
                    stuck_next = 1'b1;
                    state_next = ST_FAULT;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_FAULT: begin
                if (!EN) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign PER   = per_reg;
    assign VLD   = vld_reg;
    assign FAST  = fast_reg;
    assign SLOW  = slow_reg;
    assign STUCK = stuck_reg;
    assign OK    = (state_reg == ST_MEAS) & seen_reg & ~fast_reg & ~slow_reg & ~stuck_reg;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__clkmon.sv
// Directed bench for the clock-period monitor: A is generated as a square
// wave whose half-period (in CLK cycles) the main sequence reprograms.
module tb_gf180mcu_osu_sc_gp12t3v3__clkmon;
    import gf180mcu_osu_sc_clkmon_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       A   = 1'b0;
    logic       EN  = 1'b0;
    logic [7:0] LO  = 8'd8;
    logic [7:0] HI  = 8'd12;
    logic [7:0] PER;
    logic       VLD, FAST, SLOW, STUCK, OK;

    int         checks   = 0;
    int         errors   = 0;
    int         vld_cnt  = 0;
    logic [7:0] last_per = 8'd0;
    int         a_half   = 0;
    logic       a_hold   = 1'b0;
    int         phase    = 0;
    int         rise_cnt = 0;

    gf180mcu_osu_sc_gp12t3v3__clkmon #(.CW(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .A     (A),
        .EN    (EN),
        .LO    (LO),
        .HI    (HI),
        .PER   (PER),
        .VLD   (VLD),
        .FAST  (FAST),
        .SLOW  (SLOW),
        .STUCK (STUCK),
        .OK    (OK)
    );

    always #5 CLK = ~CLK;

    // Square-wave source for A, period 2*a_half CLK cycles; a_half=0 holds a_hold.
    always @(negedge CLK) begin
        if (a_half == 0) begin
            A     = a_hold;
            phase = 0;
        end else if (phase >= a_half - 1) begin
            phase = 0;
            A     = ~A;
            if (A) rise_cnt++;
        end else begin
            phase++;
        end
    end

    always @(posedge CLK) begin
        #1;
        if (VLD === 1'b1) begin
            vld_cnt++;
            last_per = PER;
            $display("[%0t] vld per=%0d fast=%0b slow=%0b ok=%0b", $time, PER, FAST, SLOW, OK);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_vld(input int n, input int budget, input string tag);
        int target;
        target = vld_cnt + n;
        for (int k = 0; k < budget && vld_cnt < target; k++) @(negedge CLK);
        chk(tag, 32'(vld_cnt >= target), 32'd1);
    endtask

    initial begin
        int vs;
        int rs;
        logic seen;

        // Reset state
        cycles(3);
        chk("rst_per",   32'(PER),   32'd0);
        chk("rst_vld",   32'(VLD),   32'd0);
        chk("rst_fast",  32'(FAST),  32'd0);
        chk("rst_slow",  32'(SLOW),  32'd0);
        chk("rst_stuck", 32'(STUCK), 32'd0);
        chk("rst_ok",    32'(OK),    32'd0);

        // Nominal period 10 inside [8,12]
        RST = 1'b0; EN = 1'b1; a_half = 5;
        wait_vld(1, 60, "first_vld_timeout");
        chk("first_per",  32'(last_per), 32'd10);
        chk("first_ok",   32'(OK),       32'd1);
        chk("first_fast", 32'(FAST),     32'd0);
        chk("first_slow", 32'(SLOW),     32'd0);
        wait_vld(2, 60, "nom_vld_timeout");
        chk("nom_per", 32'(last_per), 32'd10);
        chk("nom_ok",  32'(OK),       32'd1);

        // Too fast: period 4 < LO, then sticky after returning to 10
        a_half = 2;
        wait_vld(3, 60, "fast_vld_timeout");
        chk("fast_per",  32'(last_per), 32'd4);
        chk("fast_flag", 32'(FAST),     32'd1);
        chk("fast_slow", 32'(SLOW),     32'd0);
        chk("fast_ok",   32'(OK),       32'd0);
        a_half = 5;
        wait_vld(3, 100, "fast_back_timeout");
        chk("fast_back_per",    32'(last_per), 32'd10);
        chk("fast_sticky",      32'(FAST),     32'd1);
        chk("fast_sticky_ok",   32'(OK),       32'd0);

        // EN low holds flags in IDLE; re-enable clears them; period 20 > HI
        EN = 1'b0;
        cycles(1);
        chk("idle_state",     32'(dut.state_reg), 32'(ST_IDLE));
        chk("idle_fast_hold", 32'(FAST),          32'd1);
        a_half = 10; EN = 1'b1;
        wait_vld(3, 150, "slow_vld_timeout");
        chk("slow_per",  32'(last_per), 32'd20);
        chk("slow_flag", 32'(SLOW),     32'd1);
        chk("slow_fast", 32'(FAST),     32'd0);
        chk("slow_ok",   32'(OK),       32'd0);

        // Stuck: A stops, counter saturates at 255
        a_half = 5;
        wait_vld(2, 100, "pre_clear_timeout");
        EN = 1'b0;
        cycles(1);
        EN = 1'b1;
        wait_vld(2, 100, "clear_vld_timeout");
        chk("clear_ok", 32'(OK), 32'd1);
        a_hold = 1'b0; a_half = 0;
        cycles(6);
        vs = vld_cnt;
        for (int k = 0; k < 400 && STUCK !== 1'b1; k++) @(negedge CLK);
        chk("stuck_flag",   32'(STUCK),         32'd1);
        chk("stuck_state",  32'(dut.state_reg), 32'(ST_FAULT));
        chk("stuck_cnt",    32'(dut.cnt_reg),   32'd255);
        chk("stuck_ok",     32'(OK),            32'd0);
        cycles(5);
        chk("stuck_no_vld", 32'(vld_cnt - vs),  32'd0);
        chk("stuck_per",    32'(PER),           32'd10);
        EN = 1'b0;
        cycles(1);
        EN = 1'b1;
        cycles(1);
        chk("reacq_state", 32'(dut.state_reg), 32'(ST_ACQ));
        chk("reacq_stuck", 32'(STUCK),         32'd0);

        // Reset mid-period while A is low
        a_half = 5;
        wait_vld(2, 100, "prerst_vld_timeout");
        for (int k = 0; k < 20 && A !== 1'b1; k++) @(negedge CLK);
        for (int k = 0; k < 20 && A !== 1'b0; k++) @(negedge CLK);
        cycles(1);
        RST = 1'b1;
        cycles(1);
        RST = 1'b0;
        rs = rise_cnt;
        chk("midrst_per",  32'(PER),  32'd0);
        chk("midrst_vld",  32'(VLD),  32'd0);
        chk("midrst_ok",   32'(OK),   32'd0);
        chk("midrst_flag", 32'({FAST, SLOW, STUCK}), 32'd0);
        wait_vld(1, 60, "postrst_vld_timeout");
        chk("postrst_rises", 32'(rise_cnt - rs), 32'd2);
        chk("postrst_per",   32'(last_per),      32'd10);

        // Inclusive window edges, then inverted window
        LO = 8'd10; HI = 8'd10;
        wait_vld(2, 100, "incl_vld_timeout");
        chk("incl_fast", 32'(FAST), 32'd0);
        chk("incl_slow", 32'(SLOW), 32'd0);
        chk("incl_ok",   32'(OK),   32'd1);
        LO = 8'd12; HI = 8'd8;
        wait_vld(1, 60, "inv_vld_timeout");
        chk("inv_fast", 32'(FAST), 32'd1);
        chk("inv_slow", 32'(SLOW), 32'd1);
        chk("inv_ok",   32'(OK),   32'd0);

        // EN falls in the same cycle the edge strobe is consumed
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLK);
            if (dut.re === 1'b1) seen = 1'b1;
        end
        chk("re_found", 32'(seen), 32'd1);
        EN = 1'b0;
        vs = vld_cnt;
        cycles(3);
        chk("enfall_no_vld", 32'(vld_cnt - vs),  32'd0);
        chk("enfall_per",    32'(PER),           32'd10);
        chk("enfall_state",  32'(dut.state_reg), 32'(ST_IDLE));
        chk("enfall_ok",     32'(OK),            32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
